intdiv_iter: RTL and testbench

Iterative radix-2 integer divider that services the integer execution unit's divide requests (DIV, DIVU, REM, REMU and their RV64 W forms). It accepts operands in the Execute stage and holds the pipeline through the hazard unit while it iterates. It then presents a registered result for the Memory-stage pipeline register to capture. It sits beside the multiplier inside the MDU.

---
 rtl/intdiv_iter.sv | 114 +++++++++++
 tb/tb_intdiv_iter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_iter.sv
// intdiv_iter: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
module intdiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IntDivE,
    input  logic [2:0]      Funct3E,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            StallE,
    input  logic            FlushE,
    output logic            DivBusyE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] DivResultE
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(XLEN + 1);

    state_t state;
    logic [CW-1:0] count;
    logic op_rem, w64, neg_q, neg_r;
    logic [XLEN-1:0] a, b, q, r;

    logic sgn, sa, sb, start, qbit, unused_funct;
    logic [XLEN-1:0] ea, eb, ma, mb, a_init, q_nx, r_nx, res_raw, res, z_raw, z_res;
    logic [XLEN:0] r_sh, diff;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return XLEN'($signed(x[31:0]));
    endfunction

    assign unused_funct = Funct3E[2];
    assign sgn = ~Funct3E[0];
    assign start = IntDivE & ~FlushE;
    assign DivBusyE = (state == IDLE && start) || state == BUSY;

    always_comb begin
        ea = W64E ? (sgn ? sext32(ForwardedSrcAE) : XLEN'(ForwardedSrcAE[31:0])) : ForwardedSrcAE;
        eb = W64E ? (sgn ? sext32(ForwardedSrcBE) : XLEN'(ForwardedSrcBE[31:0])) : ForwardedSrcBE;
        sa = sgn & ea[XLEN-1];
        sb = sgn & eb[XLEN-1];
        ma = sa ? -ea : ea;
        mb = sb ? -eb : eb;
        // W operands sit in the top 32 bits so the MSB-first shift starts at bit 31
        a_init = W64E ? ma << (XLEN - 32) : ma;
        z_raw = Funct3E[1] ? ea : '1;
        z_res = W64E ? sext32(z_raw) : z_raw;
        r_sh = {r, a[XLEN-1]};
        diff = r_sh - {1'b0, b};
        qbit = ~diff[XLEN];
        r_nx = qbit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        q_nx = (q << 1) | XLEN'(qbit);
        res_raw = op_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
        res = w64 ? sext32(res_raw) : res_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op_rem <= 1'b0;
            w64 <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            a <= '0;
            b <= '0;
            q <= '0;
            r <= '0;
            DivDoneE <= 1'b0;
            DivResultE <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_rem <= Funct3E[1];
                    w64 <= W64E;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    a <= a_init;
                    b <= mb;
                    q <= '0;
                    r <= '0;
                    count <= W64E ? CW'(32) : CW'(XLEN);
                    if (eb == '0) begin
                        state <= DONE;
                        DivDoneE <= 1'b1;
                        DivResultE <= z_res;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: if (FlushE) begin
                    state <= IDLE;
                end else begin
                    a <= a << 1;
                    r <= r_nx;
                    q <= q_nx;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= DONE;
                        DivDoneE <= 1'b1;
                        DivResultE <= res;
                    end
                end
                DONE: if (FlushE || !StallE) begin
                    state <= IDLE;
                    DivDoneE <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intdiv_iter.sv
// tb_intdiv_iter: randomized scoreboard bench for intdiv_iter against an arithmetic reference.
module tb_intdiv_iter;
    logic clk = 1'b0;
    logic reset, IntDivE, W64E, StallE, FlushE;
    logic [2:0] Funct3E;
    logic [63:0] ForwardedSrcAE, ForwardedSrcBE;
    logic DivBusyE, DivDoneE;
    logic [63:0] DivResultE;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    intdiv_iter #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .IntDivE(IntDivE), .Funct3E(Funct3E), .W64E(W64E),
        .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE),
        .StallE(StallE), .FlushE(FlushE), .DivBusyE(DivBusyE), .DivDoneE(DivDoneE),
        .DivResultE(DivResultE)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // RISC-V division semantics straight from the arithmetic definition
    function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 0) r32 = f[1] ? a32 : 32'hFFFFFFFF;
            else if (!f[0] && a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r32 = f[1] ? 32'd0 : a32;
            else if (!f[0]) r32 = f[1] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
            else r32 = f[1] ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0) r64 = f[1] ? a : '1;
        else if (!f[0] && a == 64'h8000000000000000 && b == '1) r64 = f[1] ? 64'd0 : a;
        else if (!f[0]) r64 = f[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        else r64 = f[1] ? a % b : a / b;
        return r64;
    endfunction

    logic prev_done = 1'b0;
    logic [63:0] held;
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (DivDoneE && !prev_done) begin
                if (exp_q.size() == 0) check("unexpected_done", {63'd0, DivDoneE}, 64'd0);
                else check("result", DivResultE, exp_q.pop_front());
            end else if (DivDoneE) begin
                check("held_result", DivResultE, held);
            end
            prev_done = DivDoneE;
            held = DivResultE;
        end
    end

    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int stall);
        int busy;
        bit seen;
        bit bz;
        Funct3E = f;
        W64E = w;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        IntDivE = 1'b1;
        exp_q.push_back(model(f, w, a, b));
        bz = w ? (b[31:0] == 0) : (b == 0);
        busy = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1;
            if (DivDoneE) seen = 1;
            else begin
                if (DivBusyE) busy++;
                @(negedge clk);
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy), bz ? 64'd1 : (w ? 64'd33 : 64'd65));
        IntDivE = 1'b0;
        StallE = stall > 0;
        for (int j = 0; j < stall; j++) begin
            @(negedge clk);
            #1;
            check("stall_done", 64'(DivDoneE), 64'd1);
        end
        StallE = 1'b0;
        @(negedge clk);
        #1;
        check("idle_done", 64'(DivDoneE), 64'd0);
        check("idle_busy", 64'(DivBusyE), 64'd0);
    endtask

    initial begin
        int dones;
        logic [2:0] f;
        logic w;
        logic [63:0] a, b;
        reset = 1'b1;
        IntDivE = 1'b0;
        Funct3E = 3'b100;
        W64E = 1'b0;
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;
        StallE = 1'b0;
        FlushE = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(DivBusyE), 64'd0);
        check("rst_done", 64'(DivDoneE), 64'd0);
        check("rst_result", DivResultE, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b101, 1'b0, 64'd100, 64'd7, 0);
        run_op(3'b111, 1'b0, 64'd100, 64'd7, 0);
        run_op(3'b100, 1'b0, -64'd7, 64'd2, 0);
        run_op(3'b110, 1'b0, -64'd7, 64'd2, 1);
        run_op(3'b110, 1'b0, 64'd7, -64'd2, 0);
        run_op(3'b100, 1'b0, 64'd5, 64'd0, 0);
        run_op(3'b110, 1'b0, 64'd5, 64'd0, 2);
        run_op(3'b100, 1'b0, 64'h8000000000000000, '1, 0);
        run_op(3'b110, 1'b0, 64'h8000000000000000, '1, 0);
        run_op(3'b100, 1'b1, 64'hDEADBEEF80000000, 64'h12345678FFFFFFFF, 0);
        run_op(3'b101, 1'b1, 64'hABCD0123FFFFFFFF, 64'h5A5A5A5A00000001, 0);
        run_op(3'b111, 1'b1, 64'h00000000F0000000, 64'hFFFFFFFF00000000, 0);

        Funct3E = 3'b100;
        W64E = 1'b0;
        ForwardedSrcAE = 64'd1000;
        ForwardedSrcBE = 64'd3;
        IntDivE = 1'b1;
        repeat (10) @(negedge clk);
        FlushE = 1'b1;
        IntDivE = 1'b0;
        @(negedge clk);
        #1;
        check("flush_busy", 64'(DivBusyE), 64'd0);
        check("flush_done", 64'(DivDoneE), 64'd0);
        FlushE = 1'b0;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (DivDoneE) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);

        ForwardedSrcAE = 64'h0123456789ABCDEF;
        ForwardedSrcBE = 64'd9;
        IntDivE = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        IntDivE = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_busy", 64'(DivBusyE), 64'd0);
        check("midrst_done", 64'(DivDoneE), 64'd0);
        check("midrst_result", DivResultE, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'b100, 1'b0, 64'd1000, 64'd7, 3);

        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(4, 7));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                1: begin
                    b = 64'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: b = w ? {b[63:32], 32'd0} : 64'd0;
                3: begin
                    a = w ? {a[63:32], 32'h80000000} : 64'h8000000000000000;
                    b = w ? {b[63:32], 32'hFFFFFFFF} : '1;
                end
                default: ;
            endcase
            run_op(f, w, a, b, int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
